// File: rtl/data_mem_responder.sv
// Data-memory responder: single outstanding load/store, byte-lane strobed word array,
// response after WAIT_CYCLES wait states over a valid/ready channel.
module data_mem_responder #(
    parameter int ADDR_W      = 13,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] COUNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             stateReg, stateNext;
    logic [3:0]         countReg, countNext;
    logic               capWriteReg;
    logic [ADDR_W-1:0]  capWordReg;
    logic [31:0]        capWdataReg;
    logic [3:0]         capWstrbReg;
    logic               capErrReg;
    logic               rspErrReg;

    logic               reqErr;
    logic               strbLegal;
    logic [1:0]         lowIdx;
    logic               accept;
    logic               commit;
    logic               useLive;
    logic               selWrite;
    logic               selErr;
    logic [ADDR_W-1:0]  selWord;
    logic [31:0]        selWdata;
    logic [3:0]         selWstrb;

    assign req_ready = rst && (stateReg == IDLE);
    assign rsp_valid = (stateReg == RESP);
    assign rsp_err   = rspErrReg;
    assign accept    = req_valid && req_ready;

    // Error classification of the live request, latched at acceptance.
    always_comb begin
        strbLegal = req_wstrb inside {4'b0001, 4'b0010, 4'b0100, 4'b1000,
                                      4'b0011, 4'b1100, 4'b1111};
        lowIdx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (req_wstrb[i]) lowIdx = i[1:0];
        end
        reqErr = (|req_addr[31:ADDR_W+2]) ||
                 (req_write && (!strbLegal || (lowIdx != req_addr[1:0])));
    end

    // With zero wait states the commit coincides with acceptance, so it must use the live request.
    assign useLive  = (stateReg == IDLE);
    assign selWrite = useLive ? req_write : capWriteReg;
    assign selErr   = useLive ? reqErr : capErrReg;
    assign selWord  = useLive ? req_addr[ADDR_W+1:2] : capWordReg;
    assign selWdata = useLive ? req_wdata : capWdataReg;
    assign selWstrb = useLive ? req_wstrb : capWstrbReg;
    assign commit   = rst && (stateNext == RESP) && (stateReg != RESP);

    always_comb begin
        stateNext = stateReg;
        countNext = countReg;
        case (stateReg)
            IDLE: begin
                if (req_valid) begin
                    stateNext = (WAIT_CYCLES == 0) ? RESP : WAIT;
                    countNext = COUNT_INIT;
                end
            end
            WAIT: begin
                if (countReg == 4'd0) stateNext = RESP;
                else                  countNext = countReg - 4'd1;
            end
            RESP: begin
                if (rsp_ready) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateReg  <= IDLE;
            countReg  <= 4'd0;
            rspErrReg <= 1'b0;
        end else begin
            stateReg <= stateNext;
            countReg <= countNext;
            if (commit) rspErrReg <= selErr;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            capWriteReg <= req_write;
            capWordReg  <= req_addr[ADDR_W+1:2];
            capWdataReg <= req_wdata;
            capWstrbReg <= req_wstrb;
            capErrReg   <= reqErr;
        end
    end

    // One byte-wide array per lane, each with its own registered read port.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gLane
            logic [7:0] laneMem [DEPTH];
            logic [7:0] rdLaneReg;

            always_ff @(posedge clk) begin
                if (commit && selWrite && !selErr && selWstrb[gi]) begin
                    laneMem[selWord] <= selWdata[8*gi +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (!rst) begin
                    rdLaneReg <= 8'd0;
                end else if (commit) begin
                    rdLaneReg <= (selWrite || selErr) ? 8'd0 : laneMem[selWord];
                end
            end

            assign rsp_rdata[8*gi +: 8] = rdLaneReg;
        end
    endgenerate

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed checks of data_mem_responder against a word-array reference model.
module tb_data_mem_responder;

    localparam int AW = 13;
    localparam int W  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        b_req_valid, b_req_ready, b_req_write;
    logic [31:0] b_req_addr, b_req_wdata;
    logic [3:0]  b_req_wstrb;
    logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    int compared   = 0;
    int mismatched = 0;
    bit [31:0] refMem [int];

    always #5 clk = ~clk;

    data_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dutZero (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    function automatic bit refErr(bit w, bit [31:0] a, bit [3:0] s);
        int low;
        if ((a >> (AW + 2)) != 0) return 1'b1;
        if (!w) return 1'b0;
        if (!(s inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111}))
            return 1'b1;
        low = 0;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                low = i;
                break;
            end
        end
        return low != int'(a[1:0]);
    endfunction

    // Computes the expected response and updates the model for a committed store.
    task automatic modelTxn(input bit w, input bit [31:0] a, input bit [31:0] d,
                            input bit [3:0] s, output bit [31:0] expData, output bit expErr);
        int word;
        bit [31:0] cur;
        expErr  = refErr(w, a, s);
        word    = int'(a[AW+1:2]);
        expData = 32'd0;
        if (!expErr) begin
            cur = refMem.exists(word) ? refMem[word] : 32'd0;
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
                refMem[word] = cur;
            end else begin
                expData = cur;
            end
        end
    endtask

    task automatic txnA(input bit w, input bit [31:0] a, input bit [31:0] d, input bit [3:0] s);
        bit [31:0] expData;
        bit        expErr;
        bit        acc;
        int        lat;
        modelTxn(w, a, d, s, expData, expErr);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        rsp_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                acc = 1'b1;
                break;
            end
            @(negedge clk);
        end
        compared++;
        if (!acc) begin
            mismatched++;
            $display("FAIL accept_timeout: req_ready=%0b, required 1 within 20 cycles", req_ready);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        compared++;
        if (lat !== W + 1) begin
            mismatched++;
            $display("FAIL latency: got %0d cycles, required %0d", lat, W + 1);
        end
        compared++;
        if (rsp_rdata !== expData) begin
            mismatched++;
            $display("FAIL rdata addr=%08h: got %08h, required %08h", a, rsp_rdata, expData);
        end
        compared++;
        if (rsp_err !== expErr) begin
            mismatched++;
            $display("FAIL err addr=%08h: got %0b, required %0b", a, rsp_err, expErr);
        end
        compared++;
        if (req_ready !== 1'b0) begin
            mismatched++;
            $display("FAIL ready_in_resp: got %0b, required 0", req_ready);
        end
        @(negedge clk);
        compared++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL retire: rsp_valid=%0b req_ready=%0b, required 0/1", rsp_valid, req_ready);
        end
        $display("txn %s addr=%08h wdata=%08h wstrb=%04b -> rdata=%08h err=%0b (exp %08h/%0b)",
                 w ? "ST" : "LD", a, d, s, rsp_rdata, rsp_err, expData, expErr);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_state: ready=%0b valid=%0b rdata=%08h err=%0b, required 0/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL ready_after_reset: got %0b/%0b, required 1/1", req_ready, b_req_ready);
        end
        $display("reset: ready=%0b valid=%0b", req_ready, rsp_valid);
    endtask

    task automatic test_directed();
        txnA(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
        txnA(1'b0, 32'h10, 32'h0, 4'b0000);
        txnA(1'b1, 32'h10, 32'h11223344, 4'b1111);
        txnA(1'b1, 32'h13, 32'hAA000000, 4'b1000);
        txnA(1'b0, 32'h10, 32'h0, 4'b0000);
        txnA(1'b1, 32'h12, 32'h55660000, 4'b1100);
        txnA(1'b0, 32'h10, 32'h0, 4'b0000);
        compared++;
        if (refMem[4] !== 32'h55663344) begin
            mismatched++;
            $display("FAIL model_word: got %08h, required 55663344", refMem[4]);
        end
        txnA(1'b1, 32'h12, 32'h000000FF, 4'b0001);
        txnA(1'b0, 32'h00010000, 32'h0, 4'b0000);
        txnA(1'b0, 32'h10, 32'h0, 4'b0000);
    endtask

    task automatic test_stall();
        bit [31:0] expData;
        bit        expErr;
        int        guard;
        modelTxn(1'b0, 32'h10, 32'h0, 4'b0000, expData, expErr);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wstrb = 4'b0000;
        rsp_ready = 1'b0;
        @(negedge clk);
        // A store that must not be accepted while the response is stalled.
        req_write = 1'b1; req_wdata = 32'h0BADF00D; req_wstrb = 4'b1111;
        guard = 0;
        while (!rsp_valid && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        for (int c = 0; c < 6; c++) begin
            compared++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== expData || rsp_err !== 1'b0 || req_ready !== 1'b0) begin
                mismatched++;
                $display("FAIL stall_hold c=%0d: valid=%0b rdata=%08h err=%0b ready=%0b, required 1/%08h/0/0",
                         c, rsp_valid, rsp_rdata, rsp_err, req_ready, expData);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        compared++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            mismatched++;
            $display("FAIL stall_retire: valid=%0b ready=%0b, required 0/1", rsp_valid, req_ready);
        end
        $display("stall: held 6 cycles, rdata=%08h", expData);
        txnA(1'b0, 32'h10, 32'h0, 4'b0000);
    endtask

    task automatic test_reset_midwait();
        txnA(1'b1, 32'h20, 32'h12345678, 4'b1111);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20;
        req_wdata = 32'h0000CAFE; req_wstrb = 4'b0011;
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
            mismatched++;
            $display("FAIL midwait_reset: ready=%0b valid=%0b rdata=%08h err=%0b, required 0/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(negedge clk);
        rst = 1'b1;
        $display("reset in WAIT: pending store discarded");
        txnA(1'b0, 32'h20, 32'h0, 4'b0000);
    endtask

    task automatic test_random();
        bit [3:0] legal [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
        bit [1:0] lowOf [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd0};
        bit [31:0] a;
        bit [3:0]  s;
        bit        w;
        int        k;
        for (int i = 0; i < 16; i++) txnA(1'b1, 32'h100 + 32'(4 * i), $urandom, 4'b1111);
        for (int n = 0; n < 40; n++) begin
            w = $urandom_range(0, 1) == 1;
            k = $urandom_range(0, 6);
            a = 32'h100 + 32'(4 * $urandom_range(0, 15));
            s = legal[k];
            if (w) a[1:0] = lowOf[k];
            else   a[1:0] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                s = 4'($urandom_range(0, 15));
                a[1:0] = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(15, 31));
            txnA(w, a, $urandom, s);
        end
    endtask

    task automatic test_back_to_back();
        bit [31:0] vals [4];
        bit [31:0] exp;
        for (int i = 0; i < 4; i++) vals[i] = $urandom;
        b_rsp_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            b_req_valid = 1'b1;
            b_req_write = (i < 4);
            b_req_addr  = 32'h40 + 32'(4 * (i % 4));
            b_req_wdata = vals[i % 4];
            b_req_wstrb = 4'b1111;
            exp = (i < 4) ? 32'd0 : vals[i % 4];
            compared++;
            if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL b2b_idle i=%0d: ready=%0b valid=%0b, required 1/0", i, b_req_ready, b_rsp_valid);
            end
            @(negedge clk);
            compared++;
            if (b_rsp_valid !== 1'b1 || b_req_ready !== 1'b0 || b_rsp_rdata !== exp || b_rsp_err !== 1'b0) begin
                mismatched++;
                $display("FAIL b2b_resp i=%0d: valid=%0b ready=%0b rdata=%08h err=%0b, required 1/0/%08h/0",
                         i, b_rsp_valid, b_req_ready, b_rsp_rdata, b_rsp_err, exp);
            end
            $display("b2b %s addr=%08h -> rdata=%08h (exp %08h)", (i < 4) ? "ST" : "LD",
                     b_req_addr, b_rsp_rdata, exp);
            @(negedge clk);
        end
        b_req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b1;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_wstrb = '0;
        b_rsp_ready = 1'b1;
        test_reset();
        test_directed();
        test_stall();
        test_reset_midwait();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
